// File: rtl/stone_ram_arbiter_pkg.sv
// Shared game package: grant-owner and arbiter FSM encodings, plus a helper
// that maps an owner to its per-port ack vector.
package stone_ram_arbiter_pkg;

    localparam int unsigned OWN_W   = 2;
    localparam int unsigned PORTS_N = 3;

    // Owner encoding as seen on the owner output
    typedef enum logic [OWN_W-1:0] {
        OWN_NONE = 2'd0,
        OWN_DRAW = 2'd1,
        OWN_R0   = 2'd2,
        OWN_R1   = 2'd3
    } owner_e;

    // Access sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Ack vector ordered {rope1, rope0, draw}
    function automatic logic [PORTS_N-1:0] own_onehot(input owner_e own);
        logic [PORTS_N-1:0] v;
        v = '0;
        case (own)
            OWN_DRAW: v = 3'b001;
            OWN_R0:   v = 3'b010;
            OWN_R1:   v = 3'b100;
            default:  v = 3'b000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/stone_arb_select.sv
// Grant selection for the stone RAM arbiter: draw has priority, the two rope
// ports share round-robin, and a rope port overrides draw once draw has won
// DRAW_HOLD_MAX consecutive grants while a rope was waiting.
// Ports:
//   clock, resetn        : clock, synchronous active-low reset
//   i_d_req/i_r0_req/... : pending requests
//   i_grant              : the current selection is being committed this cycle
//   o_sel_c              : selected owner (combinational)
module stone_arb_select
    import stone_ram_arbiter_pkg::*;
#(
    parameter int unsigned DRAW_HOLD_MAX = 8
) (
    input  logic   clock,
    input  logic   resetn,
    input  logic   i_d_req,
    input  logic   i_r0_req,
    input  logic   i_r1_req,
    input  logic   i_grant,
    output owner_e o_sel_c
);

    localparam int unsigned CNT_W = $clog2(DRAW_HOLD_MAX + 1);

    logic             r_ptr;   // 0: rope 0 goes next on a tie, 1: rope 1
    logic [CNT_W-1:0] r_cnt;   // consecutive draw grants with a rope waiting
    logic             w_rope_req;
    logic             w_starved;
    owner_e           w_rope;

    // With two ropes the one not served most recently is the older waiter,
    // so the round-robin pointer also resolves the starvation override.
    always_comb begin
        w_rope_req = i_r0_req | i_r1_req;
        w_starved  = w_rope_req && (r_cnt >= CNT_W'(DRAW_HOLD_MAX));
        if (i_r0_req && i_r1_req) begin
            w_rope = r_ptr ? OWN_R1 : OWN_R0;
        end else if (i_r0_req) begin
            w_rope = OWN_R0;
        end else if (i_r1_req) begin
            w_rope = OWN_R1;
        end else begin
            w_rope = OWN_NONE;
        end
        o_sel_c = (i_d_req && !w_starved) ? OWN_DRAW : w_rope;
    end

    // Pointer moves away from the rope just served; streak clears on any
    // rope grant or on a draw grant with no rope waiting.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_ptr <= 1'b0;
            r_cnt <= '0;
        end else if (i_grant) begin
            case (o_sel_c)
                OWN_DRAW: r_cnt <= w_rope_req ? r_cnt + CNT_W'(1) : '0;
                OWN_R0: begin
                    r_ptr <= 1'b1;
                    r_cnt <= '0;
                end
                OWN_R1: begin
                    r_ptr <= 1'b0;
                    r_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/stone_ram_arbiter.sv
// Three-port arbiter in front of a single-port stone RAM with one-cycle read
// latency: a read-only draw port and two read/write rope ports. Each access
// walks IDLE -> ISSUE -> WAIT -> DONE; a rope holding lock+req in DONE keeps
// the RAM for a follow-up access without re-arbitration.
// Ports:
//   clock, resetn                  : clock, synchronous active-low reset
//   d_req, d_addr                  : draw read request
//   rN_req/lock/wren/addr/wdata    : rope N request, hold, write flag, payload
//   d_ack, r0_ack, r1_ack          : one-cycle completion pulses (DONE)
//   rdata                          : read data / pre-write contents, valid with ack
//   ram_address/ram_data/ram_wren  : RAM command; ram_q returns read data
//   owner                          : 0 none, 1 draw, 2 rope0, 3 rope1
module stone_ram_arbiter
    import stone_ram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W        = 4,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned DRAW_HOLD_MAX = 8
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              r0_req,
    input  logic              r0_lock,
    input  logic              r0_wren,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    input  logic              r1_req,
    input  logic              r1_lock,
    input  logic              r1_wren,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              d_ack,
    output logic              r0_ack,
    output logic              r1_ack,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic [OWN_W-1:0]  owner
);

    state_e             r_state;
    owner_e             r_owner;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic               r_ram_wren;
    logic [DATA_W-1:0]  r_rdata;
    logic [PORTS_N-1:0] r_ack;

    owner_e             w_sel;
    owner_e             w_next_own;
    logic               w_grant;
    logic               w_lock_cont;
    logic [ADDR_W-1:0]  w_pl_addr;
    logic               w_pl_wren;
    logic [DATA_W-1:0]  w_pl_wdata;

    stone_arb_select #(
        .DRAW_HOLD_MAX (DRAW_HOLD_MAX)
    ) u_select (
        .clock    (clock),
        .resetn   (resetn),
        .i_d_req  (d_req),
        .i_r0_req (r0_req),
        .i_r1_req (r1_req),
        .i_grant  (w_grant),
        .o_sel_c  (w_sel)
    );

    // Payload source: the arbitration winner in IDLE, the current owner otherwise
    always_comb begin
        w_grant     = (r_state == IDLE) && (w_sel != OWN_NONE);
        w_lock_cont = ((r_owner == OWN_R0) && r0_lock && r0_req) ||
                      ((r_owner == OWN_R1) && r1_lock && r1_req);
        w_next_own  = (r_state == IDLE) ? w_sel : r_owner;
        w_pl_addr   = d_addr;
        w_pl_wren   = 1'b0;
        w_pl_wdata  = '0;
        case (w_next_own)
            OWN_R0: begin
                w_pl_addr  = r0_addr;
                w_pl_wren  = r0_wren;
                w_pl_wdata = r0_wdata;
            end
            OWN_R1: begin
                w_pl_addr  = r1_addr;
                w_pl_wren  = r1_wren;
                w_pl_wdata = r1_wdata;
            end
            default: ;
        endcase
    end

    // Access sequencer; latched address/data are held (not reset) so the RAM
    // command lines stay put across a reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_owner    <= OWN_NONE;
            r_ram_wren <= 1'b0;
            r_rdata    <= '0;
            r_ack      <= '0;
        end else begin
            r_ack      <= '0;
            r_ram_wren <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_owner    <= w_sel;
                        r_addr     <= w_pl_addr;
                        r_wdata    <= w_pl_wdata;
                        r_ram_wren <= w_pl_wren;
                        r_state    <= ISSUE;
                    end
                end
                ISSUE: r_state <= WAIT;
                WAIT: begin
                    r_rdata <= ram_q;
                    r_ack   <= own_onehot(r_owner);
                    r_state <= DONE;
                end
                DONE: begin
                    if (w_lock_cont) begin
                        r_addr     <= w_pl_addr;
                        r_wdata    <= w_pl_wdata;
                        r_ram_wren <= w_pl_wren;
                        r_state    <= ISSUE;
                    end else begin
                        r_owner <= OWN_NONE;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ram_address = r_addr;
    assign ram_data    = r_wdata;
    // Reset kills a write in flight at the same edge it is asserted
    assign ram_wren    = r_ram_wren & resetn;
    assign rdata       = r_rdata;
    assign owner       = r_owner;
    assign {r1_ack, r0_ack, d_ack} = r_ack;

endmodule

// File: doc/stone_ram_arbiter.md
STONE_RAM_ARBITER -- requirements
Module: stone_ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, meaning stone RAM address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning stone record width.
REQ-003 SHALL have parameter DRAW_HOLD_MAX, default 8, meaning the maximum number of consecutive draw grants allowed while a rope port waits.
REQ-004 SHALL have port clock, input, 1 bit: system clock, all logic on its rising edge.
REQ-005 SHALL have port resetn, input, 1 bit: reset, synchronous, active-low.
REQ-006 SHALL have ports d_req, d_addr, input, 1 and ADDR_W bits: draw-engine read request and address; the draw port is read-only.
REQ-007 SHALL have ports r0_req, r0_lock, r0_wren, input, 1 bit each: rope-0 request, hold-grant and write flags.
REQ-008 SHALL have ports r0_addr and r0_wdata, input, ADDR_W and DATA_W bits: rope-0 address and write data.
REQ-009 SHALL have ports r1_req, r1_lock, r1_wren, r1_addr and r1_wdata with the same widths and meaning for rope 1.
REQ-010 SHALL have ports d_ack, r0_ack, r1_ack, output, 1 bit each: one-cycle completion pulse per port.
REQ-011 SHALL have port rdata, output, DATA_W bits: registered read data, valid in the ack cycle.
REQ-012 SHALL have ports ram_address, ram_data and ram_wren, output, ADDR_W, DATA_W and 1 bits: RAM-side command.
REQ-013 SHALL have port ram_q, input, DATA_W bits: RAM read data, valid one clock after the address.
REQ-014 SHALL have port owner, output, 2 bits: current grant owner (0 none, 1 draw, 2 rope0, 3 rope1).

Function
REQ-015 SHALL implement the FSM states IDLE, ISSUE, WAIT and DONE.
REQ-016 SHALL, in IDLE with any request pending, latch the selected owner plus its address, wren and wdata, then go to ISSUE.
REQ-017 SHALL select owners as: draw first; otherwise round-robin between r0 and r1, with the pointer toggling after each rope grant.
REQ-018 SHALL grant the oldest waiting rope port ahead of draw when the draw port has won DRAW_HOLD_MAX consecutive grants while a rope request is pending; the starvation counter then clears.
REQ-019 SHALL drive ram_address and ram_data from the latched values in ISSUE only, with ram_wren equal to the latched wren for exactly that single cycle.
REQ-020 SHALL hold ram_wren at 0 in every state other than ISSUE.
REQ-021 SHALL pass through WAIT unconditionally, and SHALL capture ram_q into rdata on the WAIT-to-DONE edge.
REQ-022 SHALL, in DONE, pulse the owner's ack for one cycle; rdata then holds the read value, or the pre-write contents on a write.
REQ-023 SHALL give a fixed latency of 4 cycles from request sampled in IDLE to ack, and SHALL allow one access per 4 cycles.
REQ-024 SHALL, on leaving DONE, return to ISSUE with the same owner (no re-arbitration) if the owner is a rope port with its lock and req both high, latching its new address, wren and wdata.
REQ-025 SHALL otherwise return from DONE to IDLE.
REQ-026 SHALL require a requester to hold req and its payload until ack.
REQ-027 SHALL complete a request dropped after latching normally, including its ack pulse and any write.
REQ-028 SHALL ignore a lock asserted while req is low.
REQ-029 SHALL ignore d_addr changes after latching.
REQ-030 SHALL, when both ropes request the same address, serialize them in round-robin order; a lock holder keeps the address exclusive across its read-modify-write.
REQ-031 SHALL keep owner at 0 in IDLE and equal to the latched owner otherwise.

Reset
REQ-032 SHALL, on resetn low at a clock edge, force the state to IDLE, owner to 0, all acks to 0, ram_wren to 0, rdata to 0, the round-robin pointer to r0 and the starvation counter to 0.
REQ-033 SHALL, on reset in ISSUE, abort the write so that no wren reaches the RAM after that edge, and SHALL not generate an ack.

Structure
REQ-034 SHALL place the owner encodings (OWN_NONE, OWN_DRAW, OWN_R0, OWN_R1) and the FSM state encodings in the shared game package used by the rope and draw controllers.
REQ-035 SHALL factor the priority/round-robin/starvation selection into one sub-module, stone_arb_select, which is combinational apart from the pointer and counter registers.

Verification
REQ-036 SHALL cover: r0 write addr 3 data 32'h0120_580E, then d read addr 3 -> r0_ack at cycle 4, ram_wren high for one cycle, d_ack 4 cycles later with rdata 32'h0120_580E.
REQ-037 SHALL cover: d_req, r0_req and r1_req high in the same cycle -> grant order draw, r0, r1; acks at cycles 4, 8 and 12.
REQ-038 SHALL cover: d_req held continuously with r1_req high -> r1 granted after exactly 8 draw grants.
REQ-039 SHALL cover: r0 with lock read addr 5, then write addr 5 while r1 requests addr 5 -> r1_ack only after the r0 write ack, and r1 reads the written value.
REQ-040 SHALL cover: resetn low during ISSUE of an r1 write -> RAM addr unchanged, no r1_ack, owner 0 next cycle.
REQ-041 SHALL cover: r0_req dropped one cycle after latching -> r0_ack still pulses at cycle 4, with no extra access.
